mem_ctrl: RTL and testbench

- Load/store adapter between the CPU data port and the byte-enable word RAM (`we[3:0]`, `addr`, `data`, `q`; registered read, 1-cycle latency).
- Converts byte/half/word requests into a word address, a byte write mask and a lane-replicated write word.
- Extracts and sign/zero-extends read data from the RAM word.
- Flags misaligned, bad-size and out-of-range accesses without touching the RAM.

---
 rtl/mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Load/store adapter between a CPU data port and a byte-enable word RAM with 1-cycle read latency.
// Optional MEM_CTRL_ERR_COUNT_EN adds a saturating 16-bit count of accepted error requests.
module mem_ctrl #(
  parameter int DEPTH         = 16384,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [3:0]               ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [31:0]              ram_data,
  input  logic [31:0]              ram_q
`ifdef MEM_CTRL_ERR_COUNT_EN
  ,
  output logic [15:0]              err_count
`endif
);

  typedef enum logic {IDLE, READ} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               off_q, off_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [ADDRESS_WIDTH-1:0] word_q, word_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [31:0]              rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;

  logic [1:0]               off;
  logic [ADDRESS_WIDTH-1:0] word;
  logic                     range_err, req_err, accept;
  logic [7:0]               ld_b;
  logic [15:0]              ld_h;
  logic [31:0]              ld_data;

  assign off       = req_addr[1:0];
  assign word      = req_addr[ADDRESS_WIDTH+1:2];
  assign range_err = (req_addr >> (ADDRESS_WIDTH + 2)) != 32'd0;
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = range_err;
    case (req_size)
      2'd1:    req_err = req_err || off[0];
      2'd2:    req_err = req_err || (off != 2'd0);
      2'd3:    req_err = 1'b1;
      default: ;
    endcase
  end

  // Writes only leave the block for accepted, legal stores and never during reset.
  always_comb begin
    ram_we = 4'b0000;
    if (!reset && accept && req_we && !req_err) begin
      case (req_size)
        2'd0:    ram_we = 4'b0001 << off;
        2'd1:    ram_we = off[1] ? 4'b1100 : 4'b0011;
        default: ram_we = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (req_size)
      2'd0:    ram_data = {4{req_wdata[7:0]}};
      2'd1:    ram_data = {2{req_wdata[15:0]}};
      default: ram_data = req_wdata;
    endcase
  end

  assign ram_addr = (state_q == IDLE) ? word : word_q;

  assign ld_b = ram_q[8*off_q +: 8];
  assign ld_h = ram_q[16*off_q[1] +: 16];

  always_comb begin
    case (size_q)
      2'd0:    ld_data = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'd1:    ld_data = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_data = ram_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    word_d      = word_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_we || req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
          end else begin
            state_d = READ;
            off_d   = off;
            size_d  = req_size;
            uns_d   = req_unsigned;
            word_d  = word;
          end
        end
      end
      READ: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      word_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      word_q      <= word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef MEM_CTRL_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (accept && req_err && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= 16'd0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural byte-enable RAM (registered read).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_data, ram_q;
`ifdef MEM_CTRL_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  mem_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
`ifdef MEM_CTRL_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383] = '{default: 32'd0};

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic [3:0]  xwe;
    logic [31:0] xdata;
    logic [31:0] xrd;
    int          xlat;
    logic        xerr;
  } op_t;

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_size = size; req_unsigned = uns; req_wdata = wd;
    #1;
  endtask

  // Returns cycles from the accept edge to the response; 8 means no response.
  task automatic wait_rsp(output logic got, output int lat, output logic [31:0] rd, output logic er);
    got = 1'b0; lat = 0; rd = 32'hx; er = 1'bx;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      if (lat == 0) req_valid = 1'b0;
      lat++;
      if (rsp_valid) begin got = 1'b1; rd = rsp_rdata; er = rsp_err; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100;
    req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL reset_ram_we got %b want 0000", ram_we); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
`ifdef MEM_CTRL_ERR_COUNT_EN
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
`endif
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_word();
    logic got, er; int lat; logic [31:0] rd;
    drive(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF);
    checks++; if (ram_we !== 4'b1111) begin errors++; $display("FAIL sw_ram_we got %b want 1111", ram_we); end
    checks++; if (ram_addr !== 14'h40) begin errors++; $display("FAIL sw_ram_addr got %h want 040", ram_addr); end
    checks++; if (ram_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_ram_data got %h want deadbeef", ram_data); end
    wait_rsp(got, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency got %0d want 1", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_rsp got err=%b rd=%h want err=0 rd=0", er, rd); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_pulse_width got %b want 0", rsp_valid); end

    drive(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    checks++; if (ram_we !== 4'b0000 || ram_addr !== 14'h40) begin errors++; $display("FAIL lw_issue got we=%b addr=%h want 0000/040", ram_we, ram_addr); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'h0;
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_read_state got rdy=%b rv=%b want 0/0", req_ready, rsp_valid); end
    checks++; if (ram_addr !== 14'h40 || ram_we !== 4'b0000) begin errors++; $display("FAIL lw_addr_hold got addr=%h we=%b want 040/0000", ram_addr, ram_we); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL lw_rsp got rv=%b err=%b want 1/0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lw_ready_back got %b want 1", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_pulse_width got %b want 0", rsp_valid); end
  endtask

  task automatic test_subword();
    op_t ops [7];
    logic got, er; int lat; logic [31:0] rd;
    // RAM word 0x40 evolves DEADBEEF -> 80ADBEEF -> 1234BEEF
    ops[0] = '{1'b1, 32'h103, 2'd0, 1'b0, 32'h00000080, 4'b1000, 32'h80808080, 32'h0,        1, 1'b0};
    ops[1] = '{1'b0, 32'h103, 2'd0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 2, 1'b0};
    ops[2] = '{1'b0, 32'h103, 2'd0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h00000080, 2, 1'b0};
    ops[3] = '{1'b1, 32'h102, 2'd1, 1'b0, 32'h00001234, 4'b1100, 32'h12341234, 32'h0,        1, 1'b0};
    ops[4] = '{1'b0, 32'h102, 2'd1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h00001234, 2, 1'b0};
    ops[5] = '{1'b0, 32'h100, 2'd0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h000000EF, 2, 1'b0};
    ops[6] = '{1'b0, 32'h100, 2'd1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'hFFFFBEEF, 2, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i].we, ops[i].addr, ops[i].size, ops[i].uns, ops[i].wd);
      checks++; if (ram_we !== ops[i].xwe) begin errors++; $display("FAIL sub%0d_ram_we got %b want %b", i, ram_we, ops[i].xwe); end
      if (ops[i].we) begin
        checks++; if (ram_data !== ops[i].xdata) begin errors++; $display("FAIL sub%0d_ram_data got %h want %h", i, ram_data, ops[i].xdata); end
      end
      wait_rsp(got, lat, rd, er);
      checks++; if (lat !== ops[i].xlat) begin errors++; $display("FAIL sub%0d_latency got %0d want %0d", i, lat, ops[i].xlat); end
      checks++; if (rd !== ops[i].xrd || er !== ops[i].xerr) begin errors++; $display("FAIL sub%0d_rsp got rd=%h err=%b want rd=%h err=%b", i, rd, er, ops[i].xrd, ops[i].xerr); end
    end
  endtask

  task automatic test_errors();
    op_t ops [5];
    logic got, er; int lat; logic [31:0] rd;
    ops[0] = '{1'b0, 32'h00000101, 2'd2, 1'b0, 32'h0,        4'b0000, 32'h0, 32'h0, 1, 1'b1};
    ops[1] = '{1'b1, 32'h00000001, 2'd1, 1'b0, 32'h0000FFFF, 4'b0000, 32'h0, 32'h0, 1, 1'b1};
    ops[2] = '{1'b0, 32'h00000000, 2'd3, 1'b0, 32'h0,        4'b0000, 32'h0, 32'h0, 1, 1'b1};
    ops[3] = '{1'b1, 32'h00010000, 2'd2, 1'b0, 32'hFFFFFFFF, 4'b0000, 32'h0, 32'h0, 1, 1'b1};
    // Word 0 aliases the out-of-range store; it must still read zero.
    ops[4] = '{1'b0, 32'h00000000, 2'd2, 1'b0, 32'h0,        4'b0000, 32'h0, 32'h0, 2, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i].we, ops[i].addr, ops[i].size, ops[i].uns, ops[i].wd);
      checks++; if (ram_we !== ops[i].xwe) begin errors++; $display("FAIL err%0d_ram_we got %b want %b", i, ram_we, ops[i].xwe); end
      wait_rsp(got, lat, rd, er);
      checks++; if (lat !== ops[i].xlat) begin errors++; $display("FAIL err%0d_latency got %0d want %0d", i, lat, ops[i].xlat); end
      checks++; if (rd !== ops[i].xrd || er !== ops[i].xerr) begin errors++; $display("FAIL err%0d_rsp got rd=%h err=%b want rd=%h err=%b", i, rd, er, ops[i].xrd, ops[i].xerr); end
    end
`ifdef MEM_CTRL_ERR_COUNT_EN
    checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL err_count got %0d want 4", err_count); end
`endif
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int ready_low = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200 + 32'(4*i);
      req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hA0000000 + 32'(i);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, req_ready); end
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_store_pulses got %0d want 3", pulses); end
    drive(1'b0, 32'h204, 2'd2, 1'b0, 32'h0);
    if (req_ready !== 1'b1) ready_low++;
    @(posedge clk); #1;
    if (req_ready !== 1'b1) ready_low++;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_held_rsp got %b want 0", rsp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (req_ready !== 1'b1) ready_low++;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA0000001) begin errors++; $display("FAIL b2b_load_rsp got rv=%b rd=%h want 1/a0000001", rsp_valid, rsp_rdata); end
    @(posedge clk); #1;
    if (req_ready !== 1'b1) ready_low++;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_pulse got %b want 0", rsp_valid); end
    checks++; if (ready_low !== 1) begin errors++; $display("FAIL b2b_ready_low_cycles got %0d want 1", ready_low); end
  endtask

  task automatic test_reset_in_read();
    int seen = 0;
    drive(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_read_entered got %b want 0", req_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    if (rsp_valid === 1'b1) seen++;
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_read_idle got %b want 1", req_ready); end
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_read_no_rsp got %0d pulses want 0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_read_ready got %b want 1", req_ready); end
`ifdef MEM_CTRL_ERR_COUNT_EN
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_read_err_count got %0d want 0", err_count); end
`endif
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
    reset = 1'b1;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_in_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
